// File: rtl/retire_mon_pkg.sv
// Shared types for the retire monitor: event classes, FSM states and the
// default-width trace event record.
package retire_mon_pkg;

  typedef enum logic [2:0] {
    EV_OTHER = 3'd0,
    EV_REG   = 3'd1,
    EV_LOAD  = 3'd2,
    EV_STORE = 3'd3,
    EV_HALT  = 3'd4
  } ev_kind_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } mon_state_e;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_REG_W  = 4;
  localparam int unsigned DEF_CNT_W  = 32;

  // Event record at the default widths; the monitor builds the same layout
  // with its own parameters.
  typedef struct packed {
    ev_kind_e              kind;
    logic [DEF_CNT_W-1:0]  inum;
    logic [DEF_DATA_W-1:0] pc;
    logic [DEF_REG_W-1:0]  reg_idx;
    logic [DEF_DATA_W-1:0] value;
    logic [DEF_DATA_W-1:0] addr;
  } ev_rec_t;

  // Classification priority: halt, load, register write, store, other.
  function automatic ev_kind_e classify(input logic halt, input logic we,
                                        input logic rd, input logic wr);
    if (halt)          return EV_HALT;
    else if (we && rd) return EV_LOAD;
    else if (we)       return EV_REG;
    else if (wr)       return EV_STORE;
    else               return EV_OTHER;
  endfunction

endpackage

// File: rtl/retire_monitor_trace_fifo.sv
// Synchronous show-ahead FIFO for trace events. The head entry is visible
// on rdata whenever empty is low; push and pop in the same cycle are both
// honoured even when full.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/retire_monitor.sv
// Commit-stage monitor: classifies and numbers retired instructions, counts
// run cycles, and queues trace events until halt or watchdog expiry.
module retire_monitor
  import retire_mon_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_W      = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WDOG_LIMIT = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              retire_valid,
  input  logic [DATA_W-1:0] retire_pc,
  input  logic              rf_we,
  input  logic [REG_W-1:0]  rf_wreg,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              halt_in,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [2:0]        ev_kind,
  output logic [CNT_W-1:0]  ev_inum,
  output logic [DATA_W-1:0] ev_pc,
  output logic [REG_W-1:0]  ev_reg,
  output logic [DATA_W-1:0] ev_value,
  output logic [DATA_W-1:0] ev_addr,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              done,
  output logic              timeout,
  output logic              overflow
);

  typedef struct packed {
    ev_kind_e          kind;
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  reg_idx;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } ev_t;

  localparam int unsigned      EV_W      = $bits(ev_t);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 1);

  mon_state_e       state;
  logic [CNT_W-1:0] inst_count_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic             done_q;
  logic             timeout_q;
  logic             overflow_q;

  logic             accept;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  ev_kind_e         kind_new;
  ev_t              ev_new;
  ev_t              ev_head;
  logic [EV_W-1:0]  head_bits;

  assign accept = (state == RUN) && retire_valid;
  assign pop    = ev_valid & ev_ready;

  // Build the event for the retiring instruction, zeroing unused fields.
  always_comb begin
    kind_new       = classify(halt_in, rf_we, mem_rd, mem_wr);
    ev_new         = '0;
    ev_new.kind    = kind_new;
    ev_new.inum    = inst_count_q;
    ev_new.pc      = retire_pc;
    case (kind_new)
      EV_REG: begin
        ev_new.reg_idx = rf_wreg;
        ev_new.value   = rf_wdata;
      end
      EV_LOAD: begin
        ev_new.reg_idx = rf_wreg;
        ev_new.value   = rf_wdata;
        ev_new.addr    = mem_addr;
      end
      EV_STORE: begin
        ev_new.value = mem_data;
        ev_new.addr  = mem_addr;
      end
      default: ;
    endcase
  end

  trace_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (ev_new),
    .pop   (pop),
    .rdata (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_head = head_bits;

  // Run-state FSM with registered done/timeout flags; halt beats the watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) state <= RUN;
        RUN: begin
          if (retire_valid && halt_in) begin
            state <= DRAIN;
          end else if (cycle_count_q == WDOG_LAST) begin
            state     <= TIMEOUT;
            timeout_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Instruction/cycle counters and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_count_q  <= '0;
      cycle_count_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      if (accept) inst_count_q <= inst_count_q + CNT_W'(1);
      if (state == RUN && cycle_count_q != '1) cycle_count_q <= cycle_count_q + CNT_W'(1);
      if (accept && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  // Head fields read as zero whenever no event is pending.
  assign ev_valid    = ~fifo_empty;
  assign ev_kind     = ev_valid ? ev_head.kind    : 3'd0;
  assign ev_inum     = ev_valid ? ev_head.inum    : '0;
  assign ev_pc       = ev_valid ? ev_head.pc      : '0;
  assign ev_reg      = ev_valid ? ev_head.reg_idx : '0;
  assign ev_value    = ev_valid ? ev_head.value   : '0;
  assign ev_addr     = ev_valid ? ev_head.addr    : '0;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_retire_monitor.sv
// Bench for retire_monitor: table of retirements checked through a
// scoreboard queue, plus overflow, halt/drain, watchdog and reset sequences.
module tb_retire_monitor;
  import retire_mon_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WDOG  = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        retire_valid = 1'b0;
  logic [15:0] retire_pc = '0;
  logic        rf_we = 1'b0;
  logic [3:0]  rf_wreg = '0;
  logic [15:0] rf_wdata = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_data = '0;
  logic        halt_in = 1'b0;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic [2:0]  ev_kind;
  logic [31:0] ev_inum;
  logic [15:0] ev_pc;
  logic [3:0]  ev_reg;
  logic [15:0] ev_value;
  logic [15:0] ev_addr;
  logic [31:0] inst_count;
  logic [31:0] cycle_count;
  logic        done;
  logic        timeout;
  logic        overflow;

  always #5 clk = ~clk;

  retire_monitor #(
    .DATA_W     (16),
    .REG_W      (4),
    .CNT_W      (32),
    .FIFO_DEPTH (DEPTH),
    .WDOG_LIMIT (WDOG)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .rf_we        (rf_we),
    .rf_wreg      (rf_wreg),
    .rf_wdata     (rf_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .halt_in      (halt_in),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_kind      (ev_kind),
    .ev_inum      (ev_inum),
    .ev_pc        (ev_pc),
    .ev_reg       (ev_reg),
    .ev_value     (ev_value),
    .ev_addr      (ev_addr),
    .inst_count   (inst_count),
    .cycle_count  (cycle_count),
    .done         (done),
    .timeout      (timeout),
    .overflow     (overflow)
  );

  typedef struct {
    logic        halt;
    logic        we;
    logic        rd;
    logic        wr;
    logic [3:0]  rg;
    logic [15:0] pc;
    logic [15:0] wdata;
    logic [15:0] addr;
    logic [15:0] mdata;
    ev_kind_e    kind;
  } vec_t;

  vec_t        tbl[7];
  ev_rec_t     exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned model_inum = 0;

  function automatic vec_t mk(input logic h, input logic we, input logic rd, input logic wr,
                              input logic [3:0] rg, input logic [15:0] pc,
                              input logic [15:0] wdata, input logic [15:0] addr,
                              input logic [15:0] mdata, input ev_kind_e k);
    vec_t v;
    v.halt = h; v.we = we; v.rd = rd; v.wr = wr; v.rg = rg; v.pc = pc;
    v.wdata = wdata; v.addr = addr; v.mdata = mdata; v.kind = k;
    return v;
  endfunction

  // Expected trace record given the class the table says it must get.
  function automatic ev_rec_t expect_of(input vec_t v, input int unsigned inum);
    ev_rec_t e;
    e = '0;
    e.kind = v.kind;
    e.inum = inum;
    e.pc   = v.pc;
    if (v.kind == EV_REG || v.kind == EV_LOAD) begin
      e.reg_idx = v.rg;
      e.value   = v.wdata;
    end
    if (v.kind == EV_STORE) e.value = v.mdata;
    if (v.kind == EV_LOAD || v.kind == EV_STORE) e.addr = v.addr;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    retire_valid = 1'b0; halt_in = 1'b0; rf_we = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    retire_pc = '0; rf_wreg = '0; rf_wdata = '0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; ev_ready = 1'b0;
    clear_inputs();
    step();
    rst_n = 1'b1;
    exp_q.delete();
    model_inum = 0;
  endtask

  task automatic start();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    retire_valid = 1'b1; halt_in = v.halt; rf_we = v.we; mem_rd = v.rd; mem_wr = v.wr;
    rf_wreg = v.rg; retire_pc = v.pc; rf_wdata = v.wdata; mem_addr = v.addr;
    mem_data = v.mdata;
  endtask

  // One retirement; when the monitor should take it, record the expectation
  // (the FIFO keeps only DEPTH entries because nothing pops meanwhile).
  task automatic retire(input vec_t v, input bit accepted);
    drive_vec(v);
    step();
    clear_inputs();
    if (accepted) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(expect_of(v, model_inum));
      model_inum++;
    end
  endtask

  task automatic chk_head(input ev_rec_t e);
    chk("ev_valid", ev_valid, 1);
    chk("ev_kind", ev_kind, e.kind);
    chk("ev_inum", ev_inum, e.inum);
    chk("ev_pc", ev_pc, e.pc);
    chk("ev_reg", ev_reg, e.reg_idx);
    chk("ev_value", ev_value, e.value);
    chk("ev_addr", ev_addr, e.addr);
  endtask

  task automatic drain();
    int budget = 64;
    ev_ready = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      if (ev_valid) begin
        chk_head(exp_q[0]);
        void'(exp_q.pop_front());
      end
      step();
      budget--;
    end
    ev_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0000, 16'h0005, 16'h0000, 16'h0000, EV_REG);
    tbl[1] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 16'h0002, 16'hBEEF, 16'h0010, 16'h0000, EV_LOAD);
    tbl[2] = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'd9, 16'h0004, 16'h7777, 16'h0012, 16'h1234, EV_STORE);
    tbl[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 16'h0006, 16'h5555, 16'h0030, 16'h6666, EV_OTHER);
    tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 16'h0008, 16'hA5A5, 16'h0040, 16'h4444, EV_REG);
    tbl[5] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h000A, 16'h1111, 16'h0050, 16'h2222, EV_OTHER);
    tbl[6] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd6, 16'h0020, 16'h9999, 16'h0060, 16'h3333, EV_HALT);

    // Reset state.
    do_reset();
    chk("rst_ev_valid", ev_valid, 0);
    chk("rst_inst_count", inst_count, 0);
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_flags", {done, timeout, overflow}, 0);

    // Table run, each retirement followed by a bubble carrying junk incl. halt_in.
    start();
    for (int i = 0; i < 7; i++) begin
      retire(tbl[i], 1'b1);
      chk("inst_count", inst_count, model_inum);
      if (i == 0) chk_head(exp_q[0]);
      if (i < 6) begin
        retire_valid = 1'b0; halt_in = 1'b1; rf_we = 1'b1; mem_wr = 1'b1; rf_wreg = 4'd5;
        step();
        clear_inputs();
        chk("bubble_inst_count", inst_count, model_inum);
      end
    end
    retire(tbl[3], 1'b0);
    chk("drain_ignores_retire", inst_count, 7);
    drain();
    chk("done_before", done, 0);
    step();
    chk("done_after", done, 1);
    retire(tbl[0], 1'b0);
    chk("done_inst_count", inst_count, 7);
    chk("done_ev_valid", ev_valid, 0);

    // Fill to full, simultaneous push/pop at full, then a dropped push.
    do_reset();
    start();
    for (int i = 0; i < 10; i++) begin
      v = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 16'(i * 4), 16'(16'h0100 + i), 16'h0, 16'h0,
             EV_REG);
      if (i == 8) begin
        chk("full_overflow", overflow, 0);
        ev_ready = 1'b1;
        drive_vec(v);
        chk_head(exp_q[0]);
        step();
        clear_inputs();
        ev_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(expect_of(v, model_inum));
        model_inum++;
        chk("pushpop_overflow", overflow, 0);
      end else begin
        retire(v, 1'b1);
      end
    end
    chk("drop_overflow", overflow, 1);
    chk("drop_inst_count", inst_count, 10);
    drain();

    // Watchdog expiry.
    do_reset();
    start();
    repeat (WDOG - 1) step();
    chk("wdog_pre_timeout", timeout, 0);
    chk("wdog_pre_cycles", cycle_count, WDOG - 1);
    step();
    chk("wdog_timeout", timeout, 1);
    chk("wdog_cycles", cycle_count, WDOG);
    repeat (3) step();
    chk("wdog_cycles_frozen", cycle_count, WDOG);
    retire(tbl[0], 1'b0);
    chk("wdog_inst_count", inst_count, 0);
    chk("wdog_ev_valid", ev_valid, 0);

    // Halt on the final watchdog cycle wins.
    do_reset();
    start();
    repeat (WDOG - 1) step();
    retire(tbl[6], 1'b1);
    chk("halt_wins_timeout", timeout, 0);
    chk("halt_wins_cycles", cycle_count, WDOG);
    drain();
    step();
    chk("halt_wins_done", done, 1);
    chk("halt_wins_timeout_late", timeout, 0);

    // Reset mid-run discards queued events; IDLE ignores retirements.
    do_reset();
    start();
    for (int i = 0; i < 4; i++) retire(tbl[i], 1'b1);
    chk("mid_ev_valid", ev_valid, 1);
    do_reset();
    chk("mid_rst_ev_valid", ev_valid, 0);
    chk("mid_rst_counts", {inst_count, cycle_count}, 0);
    chk("mid_rst_flags", {done, timeout, overflow}, 0);
    retire(tbl[0], 1'b0);
    chk("idle_inst_count", inst_count, 0);
    chk("idle_ev_valid", ev_valid, 0);
    chk("idle_cycle_count", cycle_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/retire_monitor.md
Name: retire_monitor

Overview:
Synthesizable commit-stage monitor for the pipelined CPU; successor to the single-cycle trace hooks. Observes one retire port at write-back and ignores pipeline bubbles. Classifies each retired instruction (reg write, load, store, halt, other), numbers it, counts cycles and instructions, and buffers trace events in a FIFO. Terminates on halt or a watchdog timeout; the bench or a debug port drains the FIFO.

Parameters:
DATA_W, 16, data/PC/address width
REG_W, 4, register index width
CNT_W, 32, instruction/cycle counter width
FIFO_DEPTH, 8, trace event entries (power of 2, >=2)
WDOG_LIMIT, 100000, cycles in RUN before timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  start monitoring (IDLE->RUN)
retire_valid  in  1  instruction retires this cycle (0 = bubble)
retire_pc  in  DATA_W  PC of retiring instruction
rf_we  in  1  retiring instruction writes register file
rf_wreg  in  REG_W  destination register
rf_wdata  in  DATA_W  write-back data
mem_rd  in  1  retiring instruction was a load
mem_wr  in  1  retiring instruction was a store
mem_addr  in  DATA_W  memory address
mem_data  in  DATA_W  store data
halt_in  in  1  retiring instruction is HLT
ev_valid  out  1  trace event available
ev_ready  in  1  consumer pops event
ev_kind  out  3  event class (package enum)
ev_inum  out  CNT_W  zero-based instruction number
ev_pc  out  DATA_W  PC
ev_reg  out  REG_W  register (0 if none)
ev_value  out  DATA_W  reg data or store data
ev_addr  out  DATA_W  memory address (0 if none)
inst_count  out  CNT_W  retired instructions
cycle_count  out  CNT_W  cycles spent in RUN
done  out  1  halt seen and FIFO drained
timeout  out  1  watchdog expired (sticky)
overflow  out  1  an event was dropped (sticky)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, FIFO empty, all outputs 0. Reset mid-run discards buffered events.
- FSM: IDLE -(en)-> RUN; RUN -(retire_valid&halt_in)-> DRAIN; RUN -(cycle_count==WDOG_LIMIT-1, no halt this cycle)-> TIMEOUT; DRAIN -(FIFO empty)-> DONE. DONE/TIMEOUT are terminal until reset. Halt and watchdog expiry in the same cycle: halt wins.
- cycle_count increments every cycle in RUN only; saturates at all-ones.
- Retirement is accepted only in RUN with retire_valid=1; bubbles create no event and no count.
- Classification priority: halt_in -> EV_HALT; rf_we&mem_rd -> EV_LOAD; rf_we -> EV_REG; mem_wr -> EV_STORE; else EV_OTHER (branch/NOP). Unused fields are zeroed.
- ev_inum = inst_count before increment; inst_count increments by 1 per accepted retirement, halt included.
- Latency: event is pushed at the retire edge; ev_valid=1 with its fields the next cycle (registered show-ahead FIFO); fields stay stable while ev_valid&!ev_ready.
- Pop on ev_valid&ev_ready. Simultaneous push and pop when full succeeds (no drop).
- Push while full without pop: event dropped, overflow=1, inst_count still increments.
- In DRAIN/DONE/TIMEOUT, retirements are ignored (no count, no event); pops continue.
- done=1 from the first cycle in DONE; timeout=1 from the first cycle in TIMEOUT.

Decomposition:
- retire_mon_pkg: ev_kind enum (EV_OTHER=0, EV_REG=1, EV_LOAD=2, EV_STORE=3, EV_HALT=4), FSM state enum (IDLE, RUN, DRAIN, DONE, TIMEOUT), packed event struct.
- Sub-module: trace_fifo (parametrised sync FIFO, show-ahead, full/empty, simultaneous push/pop).

Test Plan:
- Reset then en=1; retire ADD pc=0x0000 rf_we=1 reg=3 data=0x0005 -> next cycle ev_kind=EV_REG, ev_inum=0, ev_reg=3, ev_value=0x0005; inst_count=1.
- Retire load (rf_we=1, mem_rd=1, reg=2, data=0xBEEF, addr=0x0010), then bubble, then store (mem_wr=1, addr=0x0012, data=0x1234) -> EV_LOAD inum 0 addr 0x0010; EV_STORE inum 1; inst_count=2.
- ev_ready=0, retire 9 instructions with FIFO_DEPTH=8 -> 8 events kept, overflow=1, inst_count=9; then pop all -> inums 0..7 in order.
- Retire halt at pc=0x0020 with 3 events queued, ev_ready=1 -> EV_HALT last; done=1 one cycle after FIFO empties; later retire_valid pulses leave inst_count unchanged.
- WDOG_LIMIT=50, no halt -> timeout=1 and cycle_count=50 after 50 RUN cycles; halt_in on cycle 50 instead -> DRAIN, timeout stays 0.
- Assert rst_n=0 in RUN with 4 events queued -> next cycle ev_valid=0, counts 0, state IDLE.
